// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump path: dump FSM states, byte width
// and the valid/ready transfer test.
package debug_pkg;

    localparam int BYTE_WIDTH = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_CAP,
        S_SEND,
        S_DONE
    } state_t;

    // Handshake: a transfer happens on any rising edge where the producer holds
    // valid and the consumer holds ready. Valid is registered and never depends
    // on ready; once raised it holds, with the data, until that transfer.
    function automatic logic hs_xfer(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/word_serializer.sv
// Loads one DATA_WIDTH word and emits it as BPW bytes, LSB first, over a
// registered valid/ready handshake; last_o marks the final transfer.
module word_serializer
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [BYTE_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int BPW   = DATA_WIDTH / BYTE_WIDTH;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  valid_q, valid_d;
    logic                  xfer;

    assign xfer    = hs_xfer(valid_q, ready_i);
    assign data_o  = shift_q[BYTE_WIDTH-1:0];
    assign valid_o = valid_q;
    assign last_o  = xfer && (idx_q == LAST_IDX);

    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (load_i) begin
            shift_d = data_i;
            idx_d   = '0;
            valid_d = 1'b1;
        end else if (xfer) begin
            shift_d = shift_q >> BYTE_WIDTH;
            idx_d   = idx_q + IDX_W'(1);
            // Valid drops only on the transfer of the final byte of the word.
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/mem_dump_ctrl.sv
// Walks the data memory debug port from address 0 to MEM_SIZE-BPW and streams
// every word out as bytes (little endian) to the debug UART transmitter.
module mem_dump_ctrl
    import debug_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_SIZE   = 64,
    parameter int ADDR_WIDTH = $clog2(MEM_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    output logic [ADDR_WIDTH-1:0] o_debug_addr,
    input  logic [DATA_WIDTH-1:0] i_debug_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_busy,
    output logic                  o_done,
    output state_t                o_dbg_state
);

    localparam int BPW = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - BPW);
    localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BPW);

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ser_last;

    word_serializer #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ser (
        .clk    (clk),
        .rst    (rst),
        .load_i (state_q == S_CAP),
        .data_i (i_debug_data),
        .data_o (o_tx_data),
        .valid_o(o_tx_valid),
        .ready_i(i_tx_ready),
        .last_o (ser_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        state_q <= S_ADDR;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                // ADDR and WAIT give the registered debug port two edges to settle.
                S_ADDR: state_q <= S_WAIT;
                S_WAIT: state_q <= S_CAP;
                S_CAP:  state_q <= S_SEND;
                S_SEND: begin
                    if (ser_last) begin
                        // End test before increment so the address never wraps mid-dump.
                        if (addr_q == LAST_ADDR) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_ADDR;
                            addr_q  <= addr_q + STEP;
                        end
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_debug_addr = addr_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_dbg_state  = state_q;

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Randomized bench for mem_dump_ctrl: a registered memory model feeds the
// debug port and expected byte/address streams are built from memory contents.
module tb_mem_dump_ctrl;

    localparam int MEM_SIZE = 64;
    localparam int WORDS    = MEM_SIZE / 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        tx_ready = 1'b0;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;
    debug_pkg::state_t dbg_state;

    logic [31:0] mem_w [WORDS];

    mem_dump_ctrl #(.DATA_WIDTH(32), .MEM_SIZE(MEM_SIZE)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_start     (start),
        .o_debug_addr(dbg_addr),
        .i_debug_data(dbg_data),
        .o_tx_data   (tx_data),
        .o_tx_valid  (tx_valid),
        .i_tx_ready  (tx_ready),
        .o_busy      (busy),
        .o_done      (done),
        .o_dbg_state (dbg_state)
    );

    // ---- clock / memory model ----
    always #5 clk = ~clk;

    always @(posedge clk) dbg_data <= mem_w[int'(dbg_addr) / 4];

    // ---- scoreboard ----
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         addr_got[$];
    int         done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---- monitor (samples on the falling edge) ----
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_busy = 1'b0;
    logic [7:0] prev_d = '0;
    logic [5:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_v && !prev_r) begin
                check("stall_valid", {31'b0, tx_valid}, 32'd1);
                check("stall_data", {24'b0, tx_data}, {24'b0, prev_d});
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (busy && (!prev_busy || dbg_addr != prev_addr)) addr_got.push_back(int'(dbg_addr));
            if (done) begin
                done_cnt++;
                check("busy_at_done", {31'b0, busy}, 32'd0);
                check("busy_before_done", {31'b0, prev_busy}, 32'd1);
            end
        end
        prev_v    = tx_valid && !rst;
        prev_r    = tx_ready;
        prev_d    = tx_data;
        prev_busy = busy && !rst;
        prev_addr = dbg_addr;
    end

    // ---- driver tasks ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < WORDS; i++) mem_w[i] = $urandom;
    endtask

    // Runs one dump. restart_at/abort_at < 0 disables the extra start pulse / reset.
    task automatic run_dump(input int duty, input int restart_at, input int abort_at);
        bit restarted = 0;
        int cyc;
        exp_q.delete();
        got_q.delete();
        addr_got.delete();
        done_cnt = 0;
        for (int w = 0; w < WORDS; w++)
            for (int b = 0; b < 4; b++) exp_q.push_back(mem_w[w][8*b +: 8]);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        tick();
        check("lat_valid_1", {31'b0, tx_valid}, 32'd0);
        tick();
        check("lat_valid_2", {31'b0, tx_valid}, 32'd0);
        tick();
        check("lat_valid_3", {31'b0, tx_valid}, 32'd1);
        for (cyc = 0; cyc < 3000 && done_cnt == 0; cyc++) begin
            tx_ready = ($urandom_range(99) < duty);
            if (restart_at >= 0 && !restarted && got_q.size() >= restart_at) begin
                start = 1'b1;
                restarted = 1;
            end else begin
                start = 1'b0;
            end
            if (abort_at >= 0 && got_q.size() >= abort_at) begin
                rst = 1'b1;
                tick();
                check("abort_valid", {31'b0, tx_valid}, 32'd0);
                check("abort_busy", {31'b0, busy}, 32'd0);
                check("abort_addr", {26'b0, dbg_addr}, 32'd0);
                check("abort_done", {31'b0, done}, 32'd0);
                rst = 1'b0;
                start = 1'b0;
                tick();
                return;
            end
            tick();
        end
        start = 1'b0;
        check("timeout", {31'b0, done_cnt != 0}, 32'd1);
        tx_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("done_count", done_cnt, 32'd1);
        check("byte_count", got_q.size(), MEM_SIZE);
        check("busy_idle", {31'b0, busy}, 32'd0);
        for (int i = 0; i < MEM_SIZE && i < got_q.size(); i++)
            check($sformatf("byte[%0d]", i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        check("addr_count", addr_got.size(), WORDS);
        for (int i = 0; i < WORDS && i < addr_got.size(); i++)
            check($sformatf("addr[%0d]", i), addr_got[i], 4 * i);
    endtask

    // ---- main sequence ----
    initial begin
        for (int i = 0; i < WORDS; i++) mem_w[i] = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", {31'b0, tx_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_addr", {26'b0, dbg_addr}, 32'd0);
        check("rst_data", {24'b0, tx_data}, 32'd0);
        tick();

        // All-zero memory, ready always high.
        run_dump(100, -1, -1);

        // Known first word, ready always high.
        fill_random();
        mem_w[0] = 32'h4433_2211;
        run_dump(100, -1, -1);
        if (got_q.size() >= 4) begin
            check("first_b0", {24'b0, got_q[0]}, 32'h11);
            check("first_b1", {24'b0, got_q[1]}, 32'h22);
            check("first_b2", {24'b0, got_q[2]}, 32'h33);
            check("first_b3", {24'b0, got_q[3]}, 32'h44);
        end

        // Sparse ready, known last word.
        fill_random();
        mem_w[WORDS-1] = 32'hDEAD_BEEF;
        run_dump(30, -1, -1);
        if (got_q.size() == MEM_SIZE) begin
            check("last_b0", {24'b0, got_q[60]}, 32'hEF);
            check("last_b1", {24'b0, got_q[61]}, 32'hBE);
            check("last_b2", {24'b0, got_q[62]}, 32'hAD);
            check("last_b3", {24'b0, got_q[63]}, 32'hDE);
        end

        // Second start pulse at byte 10 must be ignored.
        fill_random();
        run_dump(60, 10, -1);

        // Reset at byte 20, then a clean dump from address 0.
        fill_random();
        mem_w[0] = 32'h4433_2211;
        run_dump(100, -1, 20);
        run_dump(100, -1, -1);
        if (got_q.size() > 0) check("restart_first", {24'b0, got_q[0]}, 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
